spi_req_arbiter: RTL and testbench

- Shares one spi_master among NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's command, address and write data, then drives them stable to the master for the whole transfer.
- Issues the master enable and tracks transfer progress through the master's cs output.
- Returns the captured 32-bit read word, a per-requester done pulse, and an error flag on timeout.

---
 rtl/spi_pkg.sv | 18 +
 rtl/spi_rr_pick.sv | 31 +++
 rtl/spi_req_arbiter.sv | 138 +++++++++++++
 tb/tb_spi_req_arbiter.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI request arbiter.
package spi_pkg;

    // Arbiter sequencing: wait for a request, start the master, ride the frame, report.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_XFER   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    // Command value the master treats as a write; every other value is a read.
    localparam logic [7:0] CMD_WRITE = 8'h00;

    // A full 64-bit frame takes about 130 clk, so this leaves ample margin.
    localparam int TIMEOUT_CYCLES_DEF = 256;

endpackage

// File: rtl/spi_rr_pick.sv
// Rotating-priority picker: the first set request strictly after ptr wins, wrapping around.
module spi_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Walk candidates from farthest to nearest so the nearest set bit after ptr is the last assignment.
    always_comb begin
        valid    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand     = (32'(ptr) + 32'(k)) % 32'(NUM_REQ);
            cand_idx = IDX_W'(cand);
            if (req[cand_idx]) begin
                valid = 1'b1;
                idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master among NUM_REQ requesters, with abort on timeout.
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [8*NUM_REQ-1:0]       req_cmd,
    input  logic [24*NUM_REQ-1:0]      req_addr,
    input  logic [32*NUM_REQ-1:0]      req_wdata,
    output logic [NUM_REQ-1:0]         done,
    output logic                       err,
    output logic [31:0]                rdata,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       spi_en,
    output logic [7:0]                 spi_cmd,
    output logic [23:0]                spi_addr,
    output logic [31:0]                spi_wdata,
    input  logic                       spi_cs,
    input  logic [31:0]                spi_rdata
);

    localparam int                 ID_W    = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE_HOT = NUM_REQ'(1);
    localparam logic [TO_W-1:0]    TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       state;
    logic [ID_W-1:0]  ptr;
    logic [TO_W-1:0]  to_cnt;
    logic             pick_valid;
    logic [ID_W-1:0]  pick_idx;
    logic [7:0]       cmd_sel;
    logic [23:0]      addr_sel;
    logic [31:0]      wdata_sel;
    logic             to_hit;

    spi_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Route the candidate winner's command fields so they can be latched on the grant edge.
    always_comb begin
        cmd_sel   = '0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                cmd_sel   = req_cmd[8*i +: 8];
                addr_sel  = req_addr[24*i +: 24];
                wdata_sel = req_wdata[32*i +: 32];
            end
        end
    end

    // The cycle that would push LAUNCH+XFER past the budget ends the transfer instead.
    always_comb to_hit = (to_cnt == TO_LAST);

    // Arbitration FSM with registered outputs; the timeout takes priority over a cs edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            gnt_id    <= '0;
            spi_en    <= 1'b0;
            spi_cmd   <= '0;
            spi_addr  <= '0;
            spi_wdata <= '0;
            ptr       <= ID_W'(NUM_REQ - 1);
            to_cnt    <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        gnt_id    <= pick_idx;
                        spi_cmd   <= cmd_sel;
                        spi_addr  <= addr_sel;
                        spi_wdata <= wdata_sel;
                        spi_en    <= 1'b1;
                        to_cnt    <= '0;
                        busy      <= 1'b1;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    if (to_hit) begin
                        spi_en <= 1'b0;
                        done   <= ONE_HOT << gnt_id;
                        err    <= 1'b1;
                        state  <= ST_DONE;
                    end else if (!spi_cs) begin
                        spi_en <= 1'b0;
                        state  <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    to_cnt <= to_cnt + TO_W'(1);
                    spi_en <= 1'b0;
                    if (to_hit) begin
                        done  <= ONE_HOT << gnt_id;
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else if (spi_cs) begin
                        done  <= ONE_HOT << gnt_id;
                        rdata <= spi_rdata;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr   <= gnt_id;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Self-checking bench for spi_req_arbiter with a behavioural spi_master stand-in.
module tb_spi_req_arbiter;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req;
    logic [8*NR-1:0]  req_cmd;
    logic [24*NR-1:0] req_addr;
    logic [32*NR-1:0] req_wdata;
    logic [NR-1:0] done;
    logic          err;
    logic [31:0]   rdata;
    logic [IW-1:0] gnt_id;
    logic          busy;
    logic          spi_en;
    logic [7:0]    spi_cmd;
    logic [23:0]   spi_addr;
    logic [31:0]   spi_wdata;
    logic          spi_cs = 1'b1;
    logic [31:0]   spi_rdata = '0;

    logic [7:0]  cmd_a   [NR];
    logic [23:0] addr_a  [NR];
    logic [31:0] wdata_a [NR];

    int checks = 0;
    int errors = 0;

    // master model controls
    logic        master_on = 1'b1;
    int          xfer_len = 4;
    logic [31:0] next_rdata = '0;
    logic [31:0] mdrv = '0;
    logic        mact = 1'b0;
    int          mcnt = 0;

    always #5 clk = ~clk;

    spi_req_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_cmd   (req_cmd),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .spi_en    (spi_en),
        .spi_cmd   (spi_cmd),
        .spi_addr  (spi_addr),
        .spi_wdata (spi_wdata),
        .spi_cs    (spi_cs),
        .spi_rdata (spi_rdata)
    );

    // Pack the per-requester fields onto the flat buses.
    always_comb begin
        req_cmd   = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < NR; i++) begin
            req_cmd[8*i +: 8]    = cmd_a[IW'(i)];
            req_addr[24*i +: 24] = addr_a[IW'(i)];
            req_wdata[32*i +: 32] = wdata_a[IW'(i)];
        end
    end

    // Master stand-in: on en drops cs, holds it low xfer_len cycles, then raises cs with a read word.
    always @(posedge clk) begin
        if (!rst || !master_on) begin
            spi_cs <= 1'b1;
            mact   <= 1'b0;
            mcnt   <= 0;
        end else if (!mact) begin
            if (spi_en && spi_cs) begin
                mact   <= 1'b1;
                spi_cs <= 1'b0;
                mcnt   <= xfer_len;
            end
        end else if (mcnt <= 1) begin
            spi_cs    <= 1'b1;
            spi_rdata <= next_rdata;
            mdrv      <= next_rdata;
            mact      <= 1'b0;
        end else begin
            mcnt <= mcnt - 1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Round-robin reference: first requester strictly after 'last', wrapping; -1 if none.
    function automatic int rr(input logic [NR-1:0] r, input int last);
        for (int k = 1; k <= NR; k++) begin
            if (((r >> ((last + k) % NR)) & NR'(1)) != '0) return (last + k) % NR;
        end
        return -1;
    endfunction

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int n = 0; n < TO + 50; n++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        chk({tag, " returns idle"}, 32'(ok), 32'd1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One complete transfer for a request mask, checking grant, latched fields, done and rdata.
    task automatic run_xfer(input logic [NR-1:0] mask, input int eg, input logic [31:0] val, input string tag);
        bit seen = 0;
        bit stable = 1;
        int lat = 0;
        next_rdata = val;
        @(negedge clk);
        chk({tag, " idle before"}, 32'(busy), 32'd0);
        req = mask;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1;
                lat = n;
                break;
            end
        end
        chk({tag, " grant seen"}, 32'(seen), 32'd1);
        chk({tag, " grant latency"}, 32'(lat), 32'd0);
        chk({tag, " gnt_id"}, 32'(gnt_id), 32'(eg));
        chk({tag, " spi_en"}, 32'(spi_en), 32'd1);
        chk({tag, " spi_cmd"}, 32'(spi_cmd), 32'(cmd_a[IW'(eg)]));
        chk({tag, " spi_addr"}, 32'(spi_addr), 32'(addr_a[IW'(eg)]));
        chk({tag, " spi_wdata"}, spi_wdata, wdata_a[IW'(eg)]);
        seen = 0;
        for (int n = 0; n < TO + 20; n++) begin
            @(negedge clk);
            if (spi_cmd !== cmd_a[IW'(eg)] || spi_addr !== addr_a[IW'(eg)] ||
                spi_wdata !== wdata_a[IW'(eg)]) stable = 0;
            if (done != '0) begin
                seen = 1;
                break;
            end
        end
        chk({tag, " done seen"}, 32'(seen), 32'd1);
        chk({tag, " done"}, 32'(done), 32'(NR'(1) << eg));
        chk({tag, " err"}, 32'(err), 32'd0);
        chk({tag, " rdata"}, rdata, val);
        chk({tag, " fields stable"}, 32'(stable), 32'd1);
        chk({tag, " spi_en low"}, 32'(spi_en), 32'd0);
        req = '0;
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
        chk({tag, " rdata held"}, rdata, val);
    endtask

    typedef struct {
        logic [NR-1:0] mask;
        int            gnt;
        logic [31:0]   rd;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [31:0] rd_before;
        int exp_g;
        int cur;
        int rr_last;
        int ndone;
        int busy_len;
        int k;
        int cnt;
        int g1;
        int d1;
        int rises;
        int ord[4];
        bit pb;
        bit seen;
        bit re0;

        // pointer starts at 3; each row's winner becomes the new pointer
        tbl[0] = '{4'b0001, 0, 32'h1111_2222};
        tbl[1] = '{4'b1000, 3, 32'hA5A5_0F0F};
        tbl[2] = '{4'b0101, 0, 32'h3333_4444};
        tbl[3] = '{4'b0101, 2, 32'h5555_6666};
        tbl[4] = '{4'b0110, 1, 32'h7777_8888};
        tbl[5] = '{4'b1111, 2, 32'h9999_AAAA};
        tbl[6] = '{4'b0011, 0, 32'hBBBB_CCCC};
        tbl[7] = '{4'b0001, 0, 32'hDDDD_EEEE};
        tbl[8] = '{4'b1110, 1, 32'h0F0F_F0F0};

        cmd_a[0] = 8'h00; addr_a[0] = 24'h00_1234; wdata_a[0] = 32'hDEAD_BEEF;
        cmd_a[1] = 8'h01; addr_a[1] = 24'h11_0001; wdata_a[1] = 32'h0101_0101;
        cmd_a[2] = 8'h02; addr_a[2] = 24'h22_0002; wdata_a[2] = 32'h0202_0202;
        cmd_a[3] = 8'h03; addr_a[3] = 24'h33_0003; wdata_a[3] = 32'h0303_0303;

        rst = 1'b0;
        req = '0;
        repeat (3) @(negedge clk);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst err", 32'(err), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst gnt_id", 32'(gnt_id), 32'd0);
        chk("rst spi_en", 32'(spi_en), 32'd0);
        chk("rst spi_cmd", 32'(spi_cmd), 32'd0);
        chk("rst spi_addr", 32'(spi_addr), 32'd0);
        chk("rst spi_wdata", spi_wdata, 32'd0);
        rst = 1'b1;

        for (int t = 0; t < 9; t++)
            run_xfer(tbl[t].mask, tbl[t].gnt, tbl[t].rd, $sformatf("vec%0d", t));

        // Two contenders, requester 0 re-requesting after each done: order 0,2,0,2.
        pulse_reset();
        ord[0] = 0; ord[1] = 2; ord[2] = 0; ord[3] = 2;
        k = 0;
        pb = 0;
        re0 = 0;
        req = 4'b0101;
        for (int n = 0; n < 400 && k < 4; n++) begin
            @(negedge clk);
            if (busy && !pb) begin
                chk($sformatf("alt grant%0d", k), 32'(gnt_id), 32'(ord[k]));
                k++;
            end
            pb = busy;
            if (re0) begin
                req[0] = 1'b1;
                re0 = 0;
            end
            if (done[0]) begin
                req[0] = 1'b0;
                re0 = 1;
            end
        end
        chk("alt grants complete", 32'(k), 32'd4);
        req = '0;
        wait_idle("alt");

        // Timeout: master never drops cs.
        @(negedge clk);
        rd_before = rdata;
        master_on = 1'b0;
        req = 4'b0010;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1;
                break;
            end
        end
        chk("to grant seen", 32'(seen), 32'd1);
        chk("to spi_en in launch", 32'(spi_en), 32'd1);
        cnt = 0;
        for (int n = 0; n < TO + 40; n++) begin
            @(negedge clk);
            cnt++;
            if (done != '0) break;
        end
        chk("to cycles", 32'(cnt), 32'(TO));
        chk("to done", 32'(done), 32'b0010);
        chk("to err", 32'(err), 32'd1);
        chk("to rdata unchanged", rdata, rd_before);
        chk("to spi_en", 32'(spi_en), 32'd0);
        req = '0;
        @(negedge clk);
        chk("to busy after", 32'(busy), 32'd0);
        chk("to err one cycle", 32'(err), 32'd0);
        master_on = 1'b1;

        // Reset in the middle of XFER, then a fresh request is served normally.
        xfer_len = 30;
        @(negedge clk);
        req = 4'b0100;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (busy && !spi_en) begin
                seen = 1;
                break;
            end
        end
        chk("mid reached xfer", 32'(seen), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        chk("mid busy", 32'(busy), 32'd0);
        chk("mid spi_en", 32'(spi_en), 32'd0);
        chk("mid done", 32'(done), 32'd0);
        chk("mid gnt_id", 32'(gnt_id), 32'd0);
        chk("mid rdata", rdata, 32'd0);
        d1 = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done != '0) d1++;
        end
        chk("mid no done", 32'(d1), 32'd0);
        xfer_len = 4;
        run_xfer(4'b1000, 3, 32'hC0FF_EE00, "post");

        // Withdrawal: requester 1 pulses once while 0 is being served.
        @(negedge clk);
        req = 4'b0001;
        next_rdata = 32'h1234_5678;
        g1 = 0;
        d1 = 0;
        rises = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy) break;
        end
        @(negedge clk);
        req[1] = 1'b1;
        @(negedge clk);
        req[1] = 1'b0;
        seen = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = 1;
                break;
            end
        end
        chk("wd done", 32'(done), 32'b0001);
        req = '0;
        pb = 1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (busy && !pb) rises++;
            if (busy && gnt_id == 2'd1) g1++;
            if (done[1]) d1++;
            pb = busy;
        end
        chk("wd no regrant", 32'(rises), 32'd0);
        chk("wd gnt1 count", 32'(g1), 32'd0);
        chk("wd done1 count", 32'(d1), 32'd0);

        // Randomised traffic against the round-robin reference.
        pulse_reset();
        rr_last = NR - 1;
        pb = 0;
        cur = -1;
        ndone = 0;
        busy_len = 0;
        begin
            logic [7:0]  sn_cmd;
            logic [23:0] sn_addr;
            logic [31:0] sn_wdata;
            sn_cmd = '0; sn_addr = '0; sn_wdata = '0;
            for (int c = 0; c < 8000; c++) begin
                @(negedge clk);
                if (!pb) begin
                    if (req != '0) begin
                        exp_g = rr(req, rr_last);
                        chk("rand grant taken", 32'(busy), 32'd1);
                        if (busy) begin
                            chk("rand gnt_id", 32'(gnt_id), 32'(exp_g));
                            chk("rand spi_cmd", 32'(spi_cmd), 32'(cmd_a[IW'(exp_g)]));
                            chk("rand spi_addr", 32'(spi_addr), 32'(addr_a[IW'(exp_g)]));
                            chk("rand spi_wdata", spi_wdata, wdata_a[IW'(exp_g)]);
                            cur = exp_g;
                            sn_cmd = cmd_a[IW'(exp_g)];
                            sn_addr = addr_a[IW'(exp_g)];
                            sn_wdata = wdata_a[IW'(exp_g)];
                            xfer_len = int'($urandom_range(1, 6));
                            busy_len = 0;
                        end
                    end else begin
                        chk("rand stays idle", 32'(busy), 32'd0);
                    end
                end else if (busy) begin
                    busy_len++;
                    if (busy_len == TO + 10) chk("rand transfer bounded", 32'(busy_len), 32'd0);
                end
                if (done != '0) begin
                    chk("rand done", 32'(done), (cur >= 0) ? 32'(NR'(1) << cur) : 32'd0);
                    chk("rand err", 32'(err), 32'd0);
                    chk("rand rdata", rdata, mdrv);
                    chk("rand held cmd", 32'(spi_cmd), 32'(sn_cmd));
                    chk("rand held addr", 32'(spi_addr), 32'(sn_addr));
                    chk("rand held wdata", spi_wdata, sn_wdata);
                    rr_last = cur;
                    ndone++;
                    if (cur >= 0 && $urandom_range(0, 3) != 0) req[IW'(cur)] = 1'b0;
                end
                pb = busy;
                next_rdata = $urandom;
                for (int i = 0; i < NR; i++) begin
                    if (!req[IW'(i)] && $urandom_range(0, 5) == 0) begin
                        cmd_a[IW'(i)]   = 8'($urandom);
                        addr_a[IW'(i)]  = 24'($urandom);
                        wdata_a[IW'(i)] = $urandom;
                        req[IW'(i)]     = 1'b1;
                    end else if (req[IW'(i)] && $urandom_range(0, 40) == 0) begin
                        req[IW'(i)] = 1'b0;
                    end
                end
            end
        end
        req = '0;
        wait_idle("rand");
        chk("rand progress", 32'(ndone > 50), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
